// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared types and constants for the tank game bullet logic.
//   bullet_state_t : bullet controller state encoding
//   SCREEN_X_MAX   : last visible pixel column
//   SCREEN_Y_MAX   : last visible pixel row
//   FP_SHIFT       : fractional bits of the fixed-point bullet position
//   POS_W          : width of the fixed-point position / velocity words
//   sm_to_tc()     : 7-bit magnitude plus sign flag -> POS_W-bit two's complement
// -----------------------------------------------------------------------------
package tank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLIGHT = 2'd1,
    ST_WAIT   = 2'd2
  } bullet_state_t;

  localparam logic [9:0] SCREEN_X_MAX = 10'd639;
  localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

  localparam int FP_SHIFT = 3;
  localparam int POS_W    = 10 + FP_SHIFT;

  // Zero-extends the magnitude and negates it when the sign flag is set.
  function automatic logic [POS_W-1:0] sm_to_tc(input logic       i_neg,
                                                 input logic [6:0] i_mag);
    logic [POS_W-1:0] ext;
    ext = {{(POS_W-7){1'b0}}, i_mag};
    return i_neg ? (~ext + 1'b1) : ext;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector built on a registered copy of the input level.
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset (previous value -> 0)
//   i_clr   : synchronous clear of the previous value
//   i_level : level to watch
//   o_rise  : high while i_level is 1 and its previous sampled value was 0
// -----------------------------------------------------------------------------
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else if (i_clr) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  // Held high out of reset counts as an edge because r_prev starts at 0.
  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/bullet_ctrl.sv
// -----------------------------------------------------------------------------
// bullet_ctrl
// Single-bullet controller: launches from the tank on a fire edge, flies with
// a fixed-point velocity, bounces off walls, and ends on hit, lifetime expiry
// or leaving the screen, followed by a cooldown before the next shot.
//   frame_clk      : frame-rate clock
//   Reset          : asynchronous active-high reset
//   ShootBullet    : fire request level
//   TankX, TankY   : tank pixel position sampled at launch
//   sin, cos       : sign-magnitude trig of the tank angle (bit7 = sign)
//   isWall*        : wall contact at the current bullet position
//   hit            : bullet struck a tank
//   game_end       : nonzero clears the controller on the next frame
//   BulletX/Y      : bullet pixel position
//   BulletS        : bullet size, constant 2
//   BulletActive   : high while the bullet is in flight
//   Fired          : one-frame pulse on launch
// -----------------------------------------------------------------------------
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter logic [7:0] BULLET_STEP = 8'h20,
  parameter logic [9:0] LIFETIME    = 10'd300,
  parameter logic [5:0] COOLDOWN    = 6'd30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       ShootBullet,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  input  logic       isWallTop,
  input  logic       isWallBottom,
  input  logic       isWallLeft,
  input  logic       isWallRight,
  input  logic       hit,
  input  logic [1:0] game_end,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletS,
  output logic       BulletActive,
  output logic       Fired
);

  bullet_state_t    r_state;
  logic [POS_W-1:0] r_pos_x;
  logic [POS_W-1:0] r_pos_y;
  logic [POS_W-1:0] r_vel_x;
  logic [POS_W-1:0] r_vel_y;
  logic [9:0]       r_life;
  logic [5:0]       r_cool;
  logic             r_fired;
  logic             r_active;

  logic             w_clr;
  logic             w_fire;
  logic [6:0]       w_mag_x;
  logic [6:0]       w_mag_y;
  logic [POS_W-1:0] w_launch_vx;
  logic [POS_W-1:0] w_launch_vy;
  logic [POS_W-1:0] w_vx_eff;
  logic [POS_W-1:0] w_vy_eff;
  logic [POS_W-1:0] w_next_x;
  logic [POS_W-1:0] w_next_y;
  logic             w_off_screen;
  logic             w_life_end;
  logic             w_cool_end;

  assign w_clr = (game_end != 2'b00);

  edge_detect u_edge (
    .i_clk   (frame_clk),
    .i_rst   (Reset),
    .i_clr   (w_clr),
    .i_level (ShootBullet),
    .o_rise  (w_fire)
  );

  // Speed scale times trig magnitude, keeping product bits [10:4].
  assign w_mag_x = 7'(({7'b0, BULLET_STEP[6:0]} * {7'b0, cos[6:0]}) >> 4);
  assign w_mag_y = 7'(({7'b0, BULLET_STEP[6:0]} * {7'b0, sin[6:0]}) >> 4);

  // Screen Y grows downward, so a non-negative sine means moving up (negative).
  assign w_launch_vx = sm_to_tc(cos[7], w_mag_x);
  assign w_launch_vy = sm_to_tc(~sin[7], w_mag_y);

  // Wall contact reflects the component before this frame's move.
  assign w_vx_eff = (isWallLeft | isWallRight)  ? (~r_vel_x + 1'b1) : r_vel_x;
  assign w_vy_eff = (isWallTop  | isWallBottom) ? (~r_vel_y + 1'b1) : r_vel_y;

  assign w_next_x = r_pos_x + w_vx_eff;
  assign w_next_y = r_pos_y + w_vy_eff;

  // Unsigned compare also catches positions that wrapped below zero.
  assign w_off_screen = (w_next_x[POS_W-1:FP_SHIFT] > SCREEN_X_MAX) ||
                        (w_next_y[POS_W-1:FP_SHIFT] > SCREEN_Y_MAX);

  assign w_life_end = (r_life == LIFETIME - 10'd1);
  assign w_cool_end = (r_cool == COOLDOWN - 6'd1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_vel_x  <= '0;
      r_vel_y  <= '0;
      r_life   <= '0;
      r_cool   <= '0;
      r_fired  <= 1'b0;
      r_active <= 1'b0;
    end else if (w_clr) begin
      // End of round overrides everything, including a pending fire edge.
      r_state  <= ST_IDLE;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_vel_x  <= '0;
      r_vel_y  <= '0;
      r_life   <= '0;
      r_cool   <= '0;
      r_fired  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_fired <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_pos_x  <= {TankX, {FP_SHIFT{1'b0}}};
            r_pos_y  <= {TankY, {FP_SHIFT{1'b0}}};
            r_vel_x  <= w_launch_vx;
            r_vel_y  <= w_launch_vy;
            r_life   <= '0;
            r_fired  <= 1'b1;
            r_active <= 1'b1;
            r_state  <= ST_FLIGHT;
          end
        end

        ST_FLIGHT: begin
          if (hit || w_off_screen) begin
            // Position and velocity freeze; a simultaneous wall is ignored.
            r_active <= 1'b0;
            r_cool   <= '0;
            r_state  <= ST_WAIT;
          end else begin
            r_pos_x <= w_next_x;
            r_pos_y <= w_next_y;
            r_vel_x <= w_vx_eff;
            r_vel_y <= w_vy_eff;
            r_life  <= r_life + 10'd1;
            if (w_life_end) begin
              r_active <= 1'b0;
              r_cool   <= '0;
              r_state  <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (w_cool_end) begin
            r_cool  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cool <= r_cool + 6'd1;
          end
        end

        default: begin
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BulletX      = r_pos_x[POS_W-1:FP_SHIFT];
  assign BulletY      = r_pos_y[POS_W-1:FP_SHIFT];
  assign BulletS      = 10'd2;
  assign BulletActive = r_active;
  assign Fired        = r_fired;

endmodule
